// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - FRAME_HDR_LEN     : bytes in a frame header (sync + 16-bit count)
//   - state_t           : loader FSM state encoding
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_HDR_LEN     = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd5,
`endif
    ST_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader's byte-stream input, instruction-memory write port and
// status outputs.
//   byte_data/byte_valid/byte_ready : byte stream from the serial receiver
//   mem_we/mem_addr/mem_wdata       : instruction memory write port (word index)
//   cpu_hold/load_done/load_error   : core hold and load status
// Modports:
//   master : the loader (consumes bytes, drives memory and status)
//   slave  : the surrounding system (byte source, memory, core control)
// -----------------------------------------------------------------------------
interface imem_loader_if;

  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  modport master (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_loader_word_assembler
// Collects four bytes, LSB first, into a little-endian 32-bit word.
//   clk, reset : clock and asynchronous active-high reset
//   i_clear    : return to lane 0 and drop any partial word
//   i_valid    : i_byte is being accepted this cycle
//   i_byte     : incoming data byte
//   o_word     : word as it stands once i_byte lands in the current lane
//   o_complete : i_byte is the fourth byte, o_word is a full word
// -----------------------------------------------------------------------------
module imem_loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_complete
);

  // Only the three earlier lanes need storage; lane 3 comes straight from i_byte.
  logic [23:0] r_bytes;
  logic [1:0]  r_lane;

  // Shift register and lane counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bytes <= 24'd0;
      r_lane  <= 2'd0;
    end else if (i_clear) begin
      r_bytes <= 24'd0;
      r_lane  <= 2'd0;
    end else if (i_valid) begin
      // Shift right so the oldest byte ends up in the lowest lane.
      r_bytes <= {i_byte, r_bytes[23:8]};
      r_lane  <= r_lane + 2'd1;
    end else begin
      r_bytes <= r_bytes;
      r_lane  <= r_lane;
    end
  end

  assign o_word     = {i_byte, r_bytes};
  assign o_complete = i_valid && (r_lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Frames a byte stream (SYNC, COUNT_LO, COUNT_HI, 4*COUNT data bytes), writes
// the little-endian words to instruction memory and holds the core in reset
// while a frame is in progress.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : imem_loader_if.master (byte stream in, memory write port and
//                cpu_hold/load_done/load_error out; all outputs registered)
// Parameters: MEMORY_SIZE (bytes), SYNC_BYTE, TIMEOUT_CYCLES (>= 1).
// Optional feature: IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte to
// each frame that must match before load_done is raised.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE    = 1024,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [16:0] LP_CAPACITY = 17'(MEMORY_SIZE / 4);
  // The idle counter only has to reach TIMEOUT_CYCLES-1 before it fires.
  localparam int unsigned LP_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LP_TMO_W-1:0] LP_TMO_LAST = LP_TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic                r_byte_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic                r_load_error;
  logic [15:0]         r_count;
  logic [15:0]         r_index;
  logic [LP_TMO_W-1:0] r_tmo;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          r_xor;
`endif

  logic        w_accept;
  logic        w_data_accept;
  logic [31:0] w_word;
  logic        w_complete;
  logic [15:0] w_count;
  logic        w_oversize;
  logic        w_tmo_hit;
  logic        w_last_word;

  assign w_accept      = bus.byte_valid && r_byte_ready;
  assign w_data_accept = w_accept && (r_state == ST_DATA);
  assign w_count       = {bus.byte_data, r_count[7:0]};
  assign w_oversize    = {1'b0, w_count} > LP_CAPACITY;
  assign w_tmo_hit     = (r_tmo == LP_TMO_LAST);
  assign w_last_word   = (r_index + 16'd1) == r_count;

  // The assembler is held clear outside DATA so every frame starts at lane 0.
  imem_loader_word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (r_state != ST_DATA),
    .i_valid    (w_data_accept),
    .i_byte     (bus.byte_data),
    .o_word     (w_word),
    .o_complete (w_complete)
  );

  // Loader FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_count      <= 16'd0;
      r_index      <= 16'd0;
      r_tmo        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor        <= 8'd0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_byte_ready <= 1'b1;
          r_tmo        <= '0;
          if (w_accept && (bus.byte_data == SYNC_BYTE)) begin
            r_state      <= ST_CNT_LO;
            r_cpu_hold   <= 1'b1;
            r_load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor        <= 8'd0;
`endif
          end
        end
        ST_CNT_LO: begin
          if (w_accept) begin
            r_count[7:0] <= bus.byte_data;
            r_tmo        <= '0;
            r_state      <= ST_CNT_HI;
          end else if (w_tmo_hit) begin
            r_state      <= ST_IDLE;
            r_cpu_hold   <= 1'b0;
            r_load_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + LP_TMO_W'(1);
          end
        end
        ST_CNT_HI: begin
          if (w_accept) begin
            r_count <= w_count;
            r_index <= 16'd0;
            r_tmo   <= '0;
            if (w_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state      <= ST_CHECK;
`else
              r_state      <= ST_DONE;
              r_byte_ready <= 1'b0;
              r_load_done  <= 1'b1;
              r_cpu_hold   <= 1'b0;
`endif
            end else if (w_oversize) begin
              r_state      <= ST_IDLE;
              r_cpu_hold   <= 1'b0;
              r_load_error <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end else if (w_tmo_hit) begin
            r_state      <= ST_IDLE;
            r_cpu_hold   <= 1'b0;
            r_load_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + LP_TMO_W'(1);
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_tmo <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor <= r_xor ^ bus.byte_data;
`endif
            if (w_complete) begin
              // Stop accepting for the write cycle so the next byte lands after it.
              r_state      <= ST_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_addr   <= {16'd0, r_index};
              r_mem_wdata  <= w_word;
            end
          end else if (w_tmo_hit) begin
            r_state      <= ST_IDLE;
            r_cpu_hold   <= 1'b0;
            r_load_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + LP_TMO_W'(1);
          end
        end
        ST_WRITE: begin
          r_index <= r_index + 16'd1;
          if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= ST_DONE;
            r_load_done  <= 1'b1;
            r_cpu_hold   <= 1'b0;
`endif
          end else begin
            r_state      <= ST_DATA;
            r_byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            r_tmo <= '0;
            if (bus.byte_data == r_xor) begin
              r_state      <= ST_DONE;
              r_byte_ready <= 1'b0;
              r_load_done  <= 1'b1;
              r_cpu_hold   <= 1'b0;
            end else begin
              r_state      <= ST_IDLE;
              r_cpu_hold   <= 1'b0;
              r_load_error <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_state      <= ST_IDLE;
            r_cpu_hold   <= 1'b0;
            r_load_error <= 1'b1;
          end else begin
            r_tmo <= r_tmo + LP_TMO_W'(1);
          end
        end
`endif
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.load_done  = r_load_done;
  assign bus.load_error = r_load_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader (MEMORY_SIZE=1024, TIMEOUT_CYCLES=16).
// Table-driven frames, hand-written timeout/boundary/reset sequences, and
// random frames checked against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int LP_TMO = 16;
  localparam int LP_CAP = 256;

  typedef struct {
    int          len;
    int          sp;
    logic [95:0] frame;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          done;
    bit          err;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  imem_loader_if bus ();

  imem_loader #(
    .MEMORY_SIZE    (1024),
    .SYNC_BYTE      (SYNC_BYTE_DEFAULT),
    .TIMEOUT_CYCLES (LP_TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc      = 0;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int          viol     = 0;
  logic        prev_done = 1'b0;
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int unsigned wr_cyc_q  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe memory writes and completion pulses half a cycle after each edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_cyc_q.push_back(cyc);
      if (bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0) viol <= viol + 1;
    end
    if (bus.load_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (bus.cpu_hold !== 1'b0 || prev_done === 1'b1) viol <= viol + 1;
    end
    prev_done <= bus.load_done;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte from a negedge and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_byte: byte_ready stayed low for %0d cycles, expected 1", n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  // Idle cycles until load_error rises, bounded.
  task automatic wait_err(output int k);
    k = 0;
    while (bus.load_error !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  vec_t        tbl [5];
  logic [95:0] fr;
  logic [7:0]  b;
  logic [7:0]  ck;
  logic [7:0]  fq [$];
  logic [31:0] exp_w [$];
  logic [31:0] word;
  int          base_wr;
  int          base_done;
  int          cnt;
  int          ngot;
  int          k;
  bit          over;

  initial begin
    tbl[0] = '{len:11, sp:0, frame:96'h0000_00A5_0200_1300_0000_9300_1000,
               nwr:2, w0:32'h00000013, w1:32'h00100093, done:1'b1, err:1'b0};
    tbl[1] = '{len:3, sp:0, frame:96'h0000_0000_0000_0000_00A5_0000,
               nwr:0, w0:32'h0, w1:32'h0, done:1'b1, err:1'b0};
    tbl[2] = '{len:3, sp:0, frame:96'h0000_0000_0000_0000_00A5_0101,
               nwr:0, w0:32'h0, w1:32'h0, done:1'b0, err:1'b1};
    tbl[3] = '{len:9, sp:2, frame:96'h0000_0000_00FF_A501_0078_5634_12,
               nwr:1, w0:32'h12345678, w1:32'h0, done:1'b1, err:1'b0};
    tbl[4] = '{len:7, sp:0, frame:96'h0000_0000_0000_A501_00A5_A5A5_A5,
               nwr:1, w0:32'hA5A5A5A5, w1:32'h0, done:1'b1, err:1'b0};

    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset values.
    #2 reset = 1'b1;
    @(negedge clk);
    check1("rst_byte_ready", bus.byte_ready, 1'b0);
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0);
    check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check1("rst_cpu_hold", bus.cpu_hold, 1'b0);
    check1("rst_load_done", bus.load_done, 1'b0);
    check1("rst_load_error", bus.load_error, 1'b0);
    reset = 1'b0;
    idle(2);
    check1("idle_byte_ready", bus.byte_ready, 1'b1);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      base_wr   = wr_addr_q.size();
      base_done = done_cnt;
      fr        = tbl[v].frame;
      ck        = 8'h00;
      for (int i = 0; i < tbl[v].len; i++) begin
        b = fr[8*(tbl[v].len-1-i) +: 8];
        if (i >= tbl[v].sp + int'(FRAME_HDR_LEN)) ck = ck ^ b;
        send_byte(b);
        if (i == tbl[v].sp) check1("vec_hold_after_sync", bus.cpu_hold, 1'b1);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (tbl[v].done) send_byte(ck);
`endif
      idle(4);
      checki("vec_nwr", wr_addr_q.size() - base_wr, tbl[v].nwr);
      if (tbl[v].nwr > 0 && wr_addr_q.size() > base_wr) begin
        check32("vec_addr0", wr_addr_q[base_wr], 32'd0);
        check32("vec_data0", wr_data_q[base_wr], tbl[v].w0);
      end
      if (tbl[v].nwr > 1 && wr_addr_q.size() > base_wr + 1) begin
        check32("vec_addr1", wr_addr_q[base_wr+1], 32'd1);
        check32("vec_data1", wr_data_q[base_wr+1], tbl[v].w1);
`ifndef IMEM_LOADER_CHECKSUM_EN
        checki("vec_done_after_write", int'(done_cyc - wr_cyc_q[base_wr+1]), 1);
`endif
      end
      checki("vec_done", done_cnt - base_done, tbl[v].done ? 1 : 0);
      check1("vec_error", bus.load_error, tbl[v].err);
      check1("vec_hold_end", bus.cpu_hold, 1'b0);
    end

    // Timeout: one data byte then silence.
    base_wr   = wr_addr_q.size();
    base_done = done_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    wait_err(k);
    checki("timeout_cycles", k, LP_TMO);
    check1("timeout_hold", bus.cpu_hold, 1'b0);
    checki("timeout_nwr", wr_addr_q.size() - base_wr, 0);
    checki("timeout_done", done_cnt - base_done, 0);

    // Count equal to capacity is legal; silence afterwards times out.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    check1("cap_no_error", bus.load_error, 1'b0);
    check1("cap_hold", bus.cpu_hold, 1'b1);
    wait_err(k);
    checki("cap_timeout_cycles", k, LP_TMO);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad.
    for (int t = 0; t < 2; t++) begin
      base_wr   = wr_addr_q.size();
      base_done = done_cnt;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte((t == 0) ? 8'h0F : 8'h0E);
      idle(4);
      checki("ck_nwr", wr_addr_q.size() - base_wr, 1);
      if (wr_addr_q.size() > base_wr) check32("ck_data", wr_data_q[base_wr], 32'h08040201);
      checki("ck_done", done_cnt - base_done, (t == 0) ? 1 : 0);
      check1("ck_error", bus.load_error, (t == 0) ? 1'b0 : 1'b1);
      check1("ck_hold", bus.cpu_hold, 1'b0);
    end
`endif

    // Random frames against the frame-level model.
    for (int f = 0; f < 24; f++) begin
      fq.delete();
      exp_w.delete();
      if ($urandom_range(0, 7) == 0) cnt = int'($urandom_range(257, 400));
      else cnt = int'($urandom_range(0, 6));
      over = (cnt > LP_CAP);
      ck   = 8'h00;
      fq.push_back(SYNC_BYTE_DEFAULT);
      fq.push_back(cnt[7:0]);
      fq.push_back(cnt[15:8]);
      if (!over) begin
        for (int i = 0; i < cnt; i++) begin
          word = 32'd0;
          for (int j = 0; j < 4; j++) begin
            b = 8'($urandom);
            fq.push_back(b);
            ck   = ck ^ b;
            word = word + (32'(b) << (8 * j));
          end
          exp_w.push_back(word);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        fq.push_back(ck);
`endif
      end
      base_wr   = wr_addr_q.size();
      base_done = done_cnt;
      foreach (fq[i]) begin
        idle(int'($urandom_range(0, 3)));
        send_byte(fq[i]);
      end
      idle(4);
      ngot = wr_addr_q.size() - base_wr;
      checki("rnd_nwr", ngot, exp_w.size());
      for (int i = 0; i < exp_w.size() && i < ngot; i++) begin
        check32("rnd_addr", wr_addr_q[base_wr+i], 32'(i));
        check32("rnd_data", wr_data_q[base_wr+i], exp_w[i]);
      end
      checki("rnd_done", done_cnt - base_done, over ? 0 : 1);
      check1("rnd_error", bus.load_error, over);
      check1("rnd_hold", bus.cpu_hold, 1'b0);
    end

    // Reset in the middle of the second word.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h31 + i));
    reset = 1'b1;
    #1;
    check1("mid_rst_byte_ready", bus.byte_ready, 1'b0);
    check1("mid_rst_mem_we", bus.mem_we, 1'b0);
    check32("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    check32("mid_rst_mem_wdata", bus.mem_wdata, 32'h0);
    check1("mid_rst_cpu_hold", bus.cpu_hold, 1'b0);
    check1("mid_rst_load_done", bus.load_done, 1'b0);
    check1("mid_rst_load_error", bus.load_error, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    base_wr   = wr_addr_q.size();
    base_done = done_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    idle(4);
    checki("after_rst_nwr", wr_addr_q.size() - base_wr, 1);
    if (wr_addr_q.size() > base_wr) begin
      check32("after_rst_addr", wr_addr_q[base_wr], 32'h0);
      check32("after_rst_data", wr_data_q[base_wr], 32'h44332211);
    end
    checki("after_rst_done", done_cnt - base_done, 1);

    // Protocol rules watched across the whole run.
    checki("hold_ready_done_rules", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
